// File: rtl/pipeline_if_pkg.sv
// Shared constants and types for the instruction fetch stage.
// No logic; imported by the fetch top and its buffer.
package pipeline_if_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;

endpackage

// File: rtl/pipeline_if_buffer.sv
// Fetch buffer: DEPTH-entry FIFO of {pc, inst}; head visible combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller never pushes when full. Flush dominates push/pop.
module pipeline_if_buffer
  import pipeline_if_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_ent_t    push_dat,
  input  logic          pop,
  input  logic          flush,
  output fetch_ent_t    head,
  output logic [CW-1:0] count
);

  fetch_ent_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/pipeline_if.sv
// Instruction fetch stage: one outstanding word read, buffered and handed to ID (PIPELINE_IF_PERF_EN adds perf counters).
// Latency: request one cycle after leaving reset; a returned word reaches id_valid the following cycle.
// Backpressure: id_ready low holds the head; fetching pauses once buffered + in-flight words fill the buffer.
module pipeline_if
  import pipeline_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        id_ready
`ifdef PIPELINE_IF_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  if_state_t     state;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic [31:0]   last_pc;
  logic [31:0]   redir_pc;
  logic          drop;
  logic          outstanding;
  logic          push;
  logic          pop;
  logic          rsp_take;
  logic          issue_ok;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  fetch_ent_t    head;

  assign redir_pc = redirect_pc & ~32'h3;
  assign id_valid = (count != '0);
  assign pop      = id_valid && id_ready;
  assign rsp_take = (state == IF_WAIT) && mem_rsp_valid;
  assign push     = rsp_take && !drop && !redirect_valid;

  // A word still in flight after this cycle keeps its slot reserved so its response can never overflow.
  assign count_next = count - CW'(pop) + CW'(push);
  assign issue_ok   = (count_next + CW'(outstanding && !rsp_take)) < CW'(BUF_DEPTH);

  assign id_inst = id_valid ? head.inst : INST_NOP;
  assign id_pc   = id_valid ? head.pc   : last_pc;

  pipeline_if_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ('{pc: req_pc, inst: mem_rsp_data}),
    .pop      (pop),
    .flush    (redirect_valid),
    .head     (head),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IF_IDLE;
      pc            <= RESET_PC;
      req_pc        <= RESET_PC;
      last_pc       <= '0;
      drop          <= 1'b0;
      outstanding   <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= RESET_PC;
    end else begin
      if (id_valid) begin
        last_pc <= head.pc;
      end
      if (redirect_valid) begin
        pc <= redir_pc;
        case (state)
          IF_IDLE: begin
            state         <= IF_REQ;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= redir_pc;
          end
          IF_REQ: begin
            if (mem_req_ready) begin
              // The accepted old address will still answer; discard it when it does.
              state         <= IF_WAIT;
              mem_req_valid <= 1'b0;
              outstanding   <= 1'b1;
              drop          <= 1'b1;
            end else begin
              mem_req_addr <= redir_pc;
            end
          end
          IF_WAIT: begin
            if (mem_rsp_valid) begin
              state         <= IF_REQ;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= redir_pc;
              outstanding   <= 1'b0;
              drop          <= 1'b0;
            end else begin
              drop <= 1'b1;
            end
          end
          default: state <= IF_IDLE;
        endcase
      end else begin
        case (state)
          IF_IDLE: begin
            if (issue_ok) begin
              state         <= IF_REQ;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= pc;
            end
          end
          IF_REQ: begin
            if (mem_req_ready) begin
              state         <= IF_WAIT;
              mem_req_valid <= 1'b0;
              outstanding   <= 1'b1;
              req_pc        <= pc;
              pc            <= pc + PC_STEP;
            end
          end
          IF_WAIT: begin
            if (mem_rsp_valid) begin
              outstanding <= 1'b0;
              drop        <= 1'b0;
              if (issue_ok) begin
                state         <= IF_REQ;
                mem_req_valid <= 1'b1;
                mem_req_addr  <= pc;
              end else begin
                state <= IF_IDLE;
              end
            end
          end
          default: state <= IF_IDLE;
        endcase
      end
    end
  end

`ifdef PIPELINE_IF_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (id_valid && !id_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_if.sv
// Bench for pipeline_if: transaction-level model of the fetch stream plus directed scenarios.
module tb_pipeline_if;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data  = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ready;
`ifdef PIPELINE_IF_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  pipeline_if #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
`ifdef PIPELINE_IF_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int lat    = 1;
  int acc_n  = 0;
  int pop_n  = 0;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] hs_pc[$];
  logic [31:0] hs_inst[$];

  // Model: words the ID side must see, in order, plus the fetch address expected next.
  logic [31:0] m_fifo[$];
  bit          m_out;
  bit          m_drop;
  logic [31:0] m_out_addr;
  logic [31:0] m_fetch_pc;
  logic [31:0] m_exp_pc;
  int          m_fetched;
  int          m_stall;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'hC0DE_1000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_hs(input string name, input int idx, input logic [31:0] epc,
                          input logic [31:0] einst);
    if (idx >= hs_pc.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: handshake %0d never happened (only %0d seen)", name, idx, hs_pc.size());
    end else begin
      check({name, "_pc"}, hs_pc[idx], epc);
      check({name, "_inst"}, hs_inst[idx], einst);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req_valid && mem_req_ready;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_accept: got no accepted request, expected one within 40 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: answers each accepted request in order, lat cycles after acceptance.
  always @(posedge clk) begin
    #2;
    if (mq_addr.size() > 0 && cyc >= mq_due[0]) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = memword(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'hDEAD_BEEF;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      m_fifo.delete();
      m_out      = 1'b0;
      m_drop     = 1'b0;
      m_fetch_pc = RST_PC;
      m_exp_pc   = RST_PC;
      m_fetched  = 0;
      m_stall    = 0;
      acc_n      = 0;
      pop_n      = 0;
    end else begin
      check("id_valid", {31'd0, id_valid}, {31'd0, (m_fifo.size() > 0)});
      if (m_fifo.size() > 0) begin
        check("id_pc", id_pc, m_fifo[0]);
        check("id_inst", id_inst, memword(m_fifo[0]));
        if (!id_ready) m_stall++;
      end else begin
        check("id_inst_nop", id_inst, NOP);
      end
      if (mem_req_valid) check("req_addr", mem_req_addr, m_fetch_pc);

      if (id_valid && id_ready) begin
        hs_pc.push_back(id_pc);
        hs_inst.push_back(id_inst);
        pop_n++;
        check("id_order", id_pc, m_exp_pc);
        m_exp_pc = id_pc + 32'd4;
        if (m_fifo.size() > 0) void'(m_fifo.pop_front());
      end
      if (mem_rsp_valid && m_out) begin
        m_out = 1'b0;
        if (!m_drop && !redirect_valid) begin
          m_fifo.push_back(m_out_addr);
          m_fetched++;
        end
        m_drop = 1'b0;
      end
      if (mem_req_valid && mem_req_ready) begin
        check("single_outstanding", {31'd0, m_out}, 32'd0);
        m_out      = 1'b1;
        m_out_addr = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 32'd4;
        acc_n++;
        mq_addr.push_back(mem_req_addr);
        mq_due.push_back(cyc + lat);
      end
      check("no_overflow", {31'd0, ((m_fifo.size() + int'(m_out)) <= DEPTH)}, 32'd1);
      if (redirect_valid) begin
        m_fifo.delete();
        m_drop     = m_out;
        m_fetch_pc = redirect_pc & ~32'h3;
        m_exp_pc   = m_fetch_pc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected one before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx;
    logic [31:0] snap_pc;
    logic [31:0] snap_inst;

    rst            = 1'b1;
    mem_req_ready  = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b1;
    step(3);
    check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_req_addr", mem_req_addr, RST_PC);
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_inst", id_inst, 32'h0000_0013);
    check("rst_id_pc", id_pc, 32'h0);

    rst = 1'b0;
    step(1);
    check("first_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("first_req_addr", mem_req_addr, 32'h0);
    step(12);
    check_hs("seq0", 0, 32'h0, 32'hC0DE_1000);
    check_hs("seq1", 1, 32'h4, 32'hC0DE_1004);
    check_hs("seq2", 2, 32'h8, 32'hC0DE_1008);

    id_ready = 1'b0;
    step(3);
    snap_pc   = id_pc;
    snap_inst = id_inst;
    step(7);
    check("stall_buffered", acc_n - pop_n, 32'd2);
    check("stall_no_req", {31'd0, mem_req_valid}, 32'd0);
    check("stall_valid", {31'd0, id_valid}, 32'd1);
    check("stall_pc_hold", id_pc, snap_pc);
    check("stall_inst_hold", id_inst, snap_inst);
    id_ready = 1'b1;
    step(6);

    lat = 3;
    wait_accept();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step(1);
    redirect_valid = 1'b0;
    lat            = 1;
    idx            = hs_pc.size();
    step(15);
    check_hs("redir_wait", idx, 32'h0000_0100, 32'hC0DE_1100);

    lat = 2;
    wait_accept();
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2002;
    step(1);
    redirect_valid = 1'b0;
    lat            = 1;
    idx            = hs_pc.size();
    check("rsp_redir_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("rsp_redir_req_addr", mem_req_addr, 32'h0000_2000);
    step(12);
    check_hs("rsp_redir", idx, 32'h0000_2000, 32'hC0DE_3000);

    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    idx            = hs_pc.size();
    step(14);
    check_hs("wrap_hi", idx, 32'hFFFF_FFFC, 32'h3F21_EFFC);
    check_hs("wrap_lo", idx + 1, 32'h0, 32'hC0DE_1000);

    lat = 3;
    wait_accept();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    lat = 1;
    idx = hs_pc.size();
    step(14);
    check_hs("rst_wait", idx, RST_PC, 32'hC0DE_1000);
    check_hs("rst_wait_next", idx + 1, 32'h4, 32'hC0DE_1004);

`ifdef PIPELINE_IF_PERF_EN
    id_ready = 1'b0;
    step(3);
    id_ready = 1'b1;
    step(2);
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_stall", perf_stall, m_stall);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
